// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppu_pkg
// Purpose  : Shared PPU types and screen geometry for the PPU and pixel sink.
// Revision : 1.0 - initial release
// ============================================================================
package ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } ppu_mode_e;

    localparam int LCD_W          = 160;
    localparam int LCD_H          = 144;
    localparam int BYTES_PER_LINE = 40;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_DONE_LINE = 2'd2,
        ST_VBLANK    = 2'd3
    } sink_state_e;

    function automatic logic [1:0] pal_shade(input logic [7:0] bgp, input logic [1:0] px);
        return bgp[{px, 1'b0} +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_px_packer.sv
`default_nettype none
// ============================================================================
// Module   : ppu_px_packer
// Purpose  : Maps raw pixels through the palette and packs four shades/byte.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_px_packer
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_bgp,
    input  logic [1:0] i_px,
    input  logic       i_valid,
    input  logic       i_flush,
    input  logic       i_clear,
    output logic [7:0] o_byte,
    output logic       o_byte_stb
);

    logic [7:0] r_pack;
    logic [1:0] r_cnt;
    logic [7:0] r_byte;
    logic       r_stb;
    logic [1:0] w_shade;
    logic [7:0] w_merged;

    assign w_shade  = pal_shade(i_bgp, i_px);
    // Slot k occupies bits [7-2k:6-2k], so the first pixel lands in the MSBs.
    assign w_merged = r_pack | ({w_shade, 6'b000000} >> {r_cnt, 1'b0});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack <= 8'd0;
            r_cnt  <= 2'd0;
            r_byte <= 8'd0;
            r_stb  <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            if (i_clear) begin
                r_pack <= 8'd0;
                r_cnt  <= 2'd0;
            end else if (i_valid) begin
                if (r_cnt == 2'd3) begin
                    r_byte <= w_merged;
                    r_stb  <= 1'b1;
                    r_pack <= 8'd0;
                end else begin
                    r_pack <= w_merged;
                end
                r_cnt <= r_cnt + 2'd1;
            end else if (i_flush && (r_cnt != 2'd0)) begin
                r_byte <= r_pack;
                r_stb  <= 1'b1;
                r_pack <= 8'd0;
                r_cnt  <= 2'd0;
            end
        end
    end

    assign o_byte     = r_byte;
    assign o_byte_stb = r_stb;

endmodule
`default_nettype wire

// File: rtl/ppu_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module   : ppu_pixel_sink
// Purpose  : Collects PPU pixels into a packed 2bpp framebuffer byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_pixel_sink #(
    parameter int LCD_W = ppu_pkg::LCD_W,
    parameter int LCD_H = ppu_pkg::LCD_H
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        LCD_EN,
    input  logic [1:0]  PPU_MODE,
    input  logic [1:0]  PX_IN,
    input  logic        PX_valid,
    input  logic [7:0]  BGP,
    input  logic        ERR_CLR,
    output logic        FB_WE,
    output logic [12:0] FB_ADDR,
    output logic [7:0]  FB_DATA,
    output logic        FRAME_DONE,
    output logic        LINE_SHORT,
    output logic        LINE_OVER,
    output logic [7:0]  Y_CNT
);

    import ppu_pkg::*;

    localparam logic [7:0]  c_W8  = 8'(LCD_W);
    localparam logic [7:0]  c_H8  = 8'(LCD_H);
    localparam logic [12:0] c_BPL = 13'(BYTES_PER_LINE);

    sink_state_e r_state;
    sink_state_e w_next;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [12:0] r_addr;
    logic        r_frame_done;
    logic        r_short;
    logic        r_over;

    logic        w_draw;
    logic        w_vblank;
    logic        w_active;
    logic        w_in_range;
    logic        w_accept;
    logic        w_drop;
    logic        w_leave;
    logic        w_wr_event;
    logic        w_enter_vblank;
    logic [12:0] w_addr;

    assign w_draw   = (PPU_MODE == DRAW);
    assign w_vblank = (PPU_MODE == V_BLANK);

    always_comb begin
        w_next     = r_state;
        w_active   = 1'b0;
        w_in_range = 1'b0;
        w_accept   = 1'b0;
        w_drop     = 1'b0;
        w_leave    = 1'b0;
        w_wr_event = 1'b0;

        if (!LCD_EN) begin
            w_next = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:       if (w_draw) w_next = ST_ACTIVE;
                ST_ACTIVE:    if (!w_draw) w_next = ST_DONE_LINE;
                ST_DONE_LINE: begin
                    if (w_vblank)    w_next = ST_VBLANK;
                    else if (w_draw) w_next = ST_ACTIVE;
                end
                ST_VBLANK:    if (w_draw) w_next = ST_ACTIVE;
                default:      w_next = ST_OFF;
            endcase
        end

        w_active   = LCD_EN && (r_state == ST_ACTIVE) && w_draw;
        w_in_range = (r_x < c_W8) && (r_y < c_H8);
        w_accept   = w_active && PX_valid && w_in_range;
        w_drop     = w_active && PX_valid && !w_in_range;
        w_leave    = LCD_EN && (r_state == ST_ACTIVE) && !w_draw;
        // x mod 4 mirrors the packer's slot count because lines start at x=0.
        w_wr_event = (w_accept && (r_x[1:0] == 2'd3)) ||
                     (w_leave && (r_x[1:0] != 2'd0));
    end

    assign w_enter_vblank = (w_next == ST_VBLANK) && (r_state != ST_VBLANK);
    assign w_addr         = ({5'd0, r_y} * c_BPL) + {7'd0, r_x[7:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_OFF;
            r_x          <= 8'd0;
            r_y          <= 8'd0;
            r_addr       <= 13'd0;
            r_frame_done <= 1'b0;
            r_short      <= 1'b0;
            r_over       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_frame_done <= w_enter_vblank;

            if (w_wr_event) begin
                r_addr <= w_addr;
            end

            if (w_next == ST_OFF) begin
                r_x <= 8'd0;
                r_y <= 8'd0;
            end else if (w_leave) begin
                r_x <= 8'd0;
                if (r_y < c_H8) begin
                    r_y <= r_y + 8'd1;
                end
            end else if (w_enter_vblank) begin
                r_y <= 8'd0;
            end else if (w_accept) begin
                r_x <= r_x + 8'd1;
            end

            // A new error on the clearing cycle keeps its flag set.
            r_short <= (w_leave && (r_x < c_W8)) | (r_short & ~ERR_CLR);
            r_over  <= w_drop | (r_over & ~ERR_CLR);
        end
    end

    ppu_px_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_bgp      (BGP),
        .i_px       (PX_IN),
        .i_valid    (w_accept),
        .i_flush    (w_leave),
        .i_clear    (w_next == ST_OFF),
        .o_byte     (FB_DATA),
        .o_byte_stb (FB_WE)
    );

    assign FB_ADDR    = r_addr;
    assign FRAME_DONE = r_frame_done;
    assign LINE_SHORT = r_short;
    assign LINE_OVER  = r_over;
    assign Y_CNT      = r_y;

endmodule
`default_nettype wire

// File: doc/ppu_pixel_sink.md
PPU_PIXEL_SINK -- requirements
Module: ppu_pixel_sink

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- LCD_W, 160, visible pixels per line.
- LCD_H, 144, visible lines per frame.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- LCD_EN  in  1  LCDC bit 7.
- PPU_MODE  in  2  PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW.
- PX_IN  in  2  raw pixel colour index.
- PX_valid  in  1  PX_IN valid this cycle.
- BGP  in  8  background palette.
- ERR_CLR  in  1  clears sticky error flags.
- FB_WE  out  1  framebuffer byte write strobe.
- FB_ADDR  out  13  byte address, range 0..5759.
- FB_DATA  out  8  four packed 2-bit shades.
- FRAME_DONE  out  1  one-cycle end-of-frame pulse.
- LINE_SHORT  out  1  sticky: a line ended with fewer than LCD_W pixels.
- LINE_OVER  out  1  sticky: pixels arrived past LCD_W, or past line LCD_H.
- Y_CNT  out  8  current line index.

Function
REQ-003 SHALL implement states OFF, ACTIVE, DONE_LINE, VBLANK.
- OFF to ACTIVE: LCD_EN=1 and PPU_MODE=DRAW.
- ACTIVE to DONE_LINE: PPU_MODE leaves DRAW.
- DONE_LINE to ACTIVE: PPU_MODE=DRAW and PPU_MODE was DRAW on no cycle since entering DONE_LINE.
- DONE_LINE to VBLANK: PPU_MODE=V_BLANK.
- VBLANK to ACTIVE: PPU_MODE=DRAW.
- Any state to OFF: LCD_EN=0.
REQ-004 SHALL accept a pixel only when PX_valid=1, PPU_MODE=DRAW, state ACTIVE, x<LCD_W and Y_CNT<LCD_H; all other PX_valid cycles are ignored.
REQ-005 SHALL drop a PX_valid pixel while in ACTIVE with x>=LCD_W or Y_CNT>=LCD_H, and SHALL set LINE_OVER.
REQ-006 SHALL map each accepted pixel p to shade = BGP[2p+1:2p].
REQ-007 SHALL pack pixel k of each 4-pixel group (k = x mod 4) into FB_DATA bits [7-2k:6-2k].
REQ-008 SHALL assert FB_WE for exactly one cycle, on the cycle after the 4th pixel of a group is accepted, with FB_ADDR = Y_CNT*40 + x/4 (x of that group's first pixel).
REQ-009 SHALL flush a partial group on the ACTIVE to DONE_LINE transition:
- unfilled slots zero-padded;
- FB_WE asserted one cycle after the transition;
- LINE_SHORT set if x<LCD_W.
REQ-010 SHALL, on entering DONE_LINE, reset x to 0 and increment Y_CNT, saturating at LCD_H.
REQ-011 SHALL, on entering VBLANK, pulse FRAME_DONE for one cycle and reset Y_CNT to 0.
REQ-012 SHALL keep FB_WE=0 in OFF; entering OFF clears x and Y_CNT and discards any partial group without writing it.
REQ-013 SHALL let a flag set on the same cycle as ERR_CLR win (flag remains 1).
REQ-014 SHALL derive all address arithmetic from 8-bit Y_CNT and 8-bit x, widened to 13 bits before multiply and add; no wrap occurs within range.
REQ-015 SHALL tolerate back-to-back PX_valid on every cycle with no dropped pixels.

Reset
REQ-016 SHALL, on rst, set:
- state OFF;
- x=0, Y_CNT=0;
- FB_WE=0, FB_ADDR=0, FB_DATA=0;
- FRAME_DONE=0, LINE_SHORT=0, LINE_OVER=0;
- pack register=0.
REQ-017 SHALL, on rst asserted mid-line, suppress any pending write on the next cycle.

Structure
REQ-018 SHALL take the PPU mode enum (H_BLANK, V_BLANK, SCAN, DRAW), LCD_W, LCD_H and BYTES_PER_LINE=40 from shared package ppu_pkg, which the PPU also imports.
REQ-019 SHALL place palette mapping and 4-pixel packing in sub-module ppu_px_packer, with ports: pixel in, valid, flush, clear, byte out, byte strobe.

Verification
REQ-020 SHALL cover these directed scenarios:
- Full line: LCD_EN=1, BGP=0xE4, DRAW, 160 consecutive PX_valid with PX_IN cycling 0,1,2,3, then H_BLANK -> 40 writes at FB_ADDR 0..39, each FB_DATA=0x1B; Y_CNT=1; no flags set.
- Palette: BGP=0x1B, four pixels all 0 -> FB_DATA=0xFF.
- Short line: 6 pixels of value 3 with BGP=0xE4, then H_BLANK -> write addr 0 data 0xFF; write addr 1 data 0xF0; LINE_SHORT=1.
- Overrun: 165 pixels in one DRAW -> 40 writes only; LINE_OVER=1; ERR_CLR then clears it.
- Frame: 144 full lines, then V_BLANK -> last write at FB_ADDR 5759; FRAME_DONE high exactly 1 cycle; Y_CNT=0.
- Disable mid-line: 3 pixels accepted, then LCD_EN=0 -> no FB_WE; x=0, Y_CNT=0; rst mid-group -> no write on the following cycle.
